// File: rtl/vend_pkg.sv
// Shared types for the vending controller: FSM state encoding and coin values in nickels.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  localparam logic [2:0] NICKEL_V  = 3'd1;
  localparam logic [2:0] DIME_V    = 3'd2;
  localparam logic [2:0] QUARTER_V = 3'd5;

endpackage

// File: rtl/vend_ctrl_multi_if.sv
// Bus between the coin acceptor / selection panel and the vending controller.
interface vend_ctrl_multi_if #(
  parameter int NUM_PRODUCTS = 2,
  parameter int MAX_CREDIT_N = 15
) ();
  import vend_pkg::*;

  localparam int CW = $clog2(MAX_CREDIT_N + 1);

  // No valid/ready here: N/D/Q/cancel are single-cycle strobes sampled on every
  // edge; give/coin_reject/change_nickel are single-cycle registered pulses.
  logic                    N;
  logic                    D;
  logic                    Q;
  logic [NUM_PRODUCTS-1:0] sel;
  logic                    cancel;
  logic [NUM_PRODUCTS-1:0] give;
  logic [CW-1:0]           credit;
  logic                    coin_reject;
  logic                    change_nickel;
  logic                    busy;
  state_t                  state;

  modport master (
    output N, D, Q, sel, cancel,
    input  give, credit, coin_reject, change_nickel, busy, state
  );

  modport slave (
    input  N, D, Q, sel, cancel,
    output give, credit, coin_reject, change_nickel, busy, state
  );

endinterface

// File: rtl/vend_coin_arb.sv
// Coin arbitration: picks the highest coin of a cycle and rejects it if credit would overflow.
module vend_coin_arb
  import vend_pkg::*;
#(
  parameter int MAX_CREDIT_N = 15,
  parameter int CW           = 4
) (
  input  logic          n,
  input  logic          d,
  input  logic          q,
  input  logic [CW-1:0] credit,
  output logic          accept,
  output logic [2:0]    value,
  output logic          reject
);

  // Extra headroom so credit + quarter never wraps before the ceiling compare.
  localparam int SW = CW + 4;

  logic          any_coin;
  logic          multi;
  logic          over;
  logic [SW-1:0] sum;

  always_comb begin
    value = '0;
    if (q)      value = QUARTER_V;
    else if (d) value = DIME_V;
    else if (n) value = NICKEL_V;
  end

  assign any_coin = n | d | q;
  assign multi    = (n & d) | (n & q) | (d & q);
  assign sum      = SW'(credit) + SW'(value);
  assign over     = sum > SW'(MAX_CREDIT_N);
  assign accept   = any_coin & ~over;
  assign reject   = multi | (any_coin & over);

endmodule

// File: rtl/vend_ctrl_multi.sv
// Vending controller top: credit register and IDLE/CREDIT/VEND/CHANGE FSM.
// Optional change return and cancel refund are built when VEND_CHANGE_EN is defined.
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int PRICE_N      = 9,
  parameter int MAX_CREDIT_N = 15,
  parameter int NUM_PRODUCTS = 2
) (
  input  logic             CLK,
  input  logic             reset,
  vend_ctrl_multi_if.slave bus
);

  localparam int            CW      = $clog2(MAX_CREDIT_N + 1);
  localparam logic [CW-1:0] PRICE_C = CW'(PRICE_N);

  state_t                  state_r, state_n;
  logic [CW-1:0]           credit_r, credit_n;
  logic [NUM_PRODUCTS-1:0] give_r, give_n;
  logic                    rej_r, rej_n;
  logic                    busy_r;
  logic                    coin_any;
  logic                    arb_accept;
  logic                    arb_reject;
  logic [2:0]              arb_value;
  logic [NUM_PRODUCTS-1:0] sel_low;

  vend_coin_arb #(
    .MAX_CREDIT_N (MAX_CREDIT_N),
    .CW           (CW)
  ) u_arb (
    .n      (bus.N),
    .d      (bus.D),
    .q      (bus.Q),
    .credit (credit_r),
    .accept (arb_accept),
    .value  (arb_value),
    .reject (arb_reject)
  );

  assign coin_any = bus.N | bus.D | bus.Q;
  assign sel_low  = bus.sel & (~bus.sel + NUM_PRODUCTS'(1));

`ifdef VEND_CHANGE_EN
  logic chg_r, chg_n;
`else
  logic unused_cancel;
  assign unused_cancel = bus.cancel;
`endif

  // Priority within IDLE/CREDIT: coin, then cancel, then selection.
  always_comb begin
    state_n  = state_r;
    credit_n = credit_r;
    give_n   = '0;
    rej_n    = 1'b0;
`ifdef VEND_CHANGE_EN
    chg_n    = 1'b0;
`endif
    case (state_r)
      IDLE, CREDIT: begin
        if (coin_any) begin
          rej_n = arb_reject;
          if (arb_accept) begin
            credit_n = credit_r + CW'(arb_value);
            state_n  = CREDIT;
          end
        end
`ifdef VEND_CHANGE_EN
        else if (bus.cancel && state_r == CREDIT) begin
          state_n = CHANGE;
        end
`endif
        else if (state_r == CREDIT && bus.sel != '0 && credit_r >= PRICE_C) begin
          give_n   = sel_low;
          credit_n = credit_r - PRICE_C;
          state_n  = VEND;
        end
      end
      VEND: begin
        rej_n = coin_any;
`ifdef VEND_CHANGE_EN
        state_n = (credit_r != '0) ? CHANGE : IDLE;
`else
        state_n = (credit_r != '0) ? CREDIT : IDLE;
`endif
      end
`ifdef VEND_CHANGE_EN
      CHANGE: begin
        rej_n = coin_any;
        if (credit_r != '0) begin
          chg_n    = 1'b1;
          credit_n = credit_r - CW'(1);
          if (credit_r == CW'(1)) state_n = IDLE;
        end else begin
          state_n = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_r  <= IDLE;
      credit_r <= '0;
      give_r   <= '0;
      rej_r    <= 1'b0;
      busy_r   <= 1'b0;
`ifdef VEND_CHANGE_EN
      chg_r    <= 1'b0;
`endif
    end else begin
      state_r  <= state_n;
      credit_r <= credit_n;
      give_r   <= give_n;
      rej_r    <= rej_n;
      busy_r   <= (state_n == VEND) || (state_n == CHANGE);
`ifdef VEND_CHANGE_EN
      chg_r    <= chg_n;
`endif
    end
  end

  assign bus.give        = give_r;
  assign bus.credit      = credit_r;
  assign bus.coin_reject = rej_r;
  assign bus.busy        = busy_r;
  assign bus.state       = state_r;
`ifdef VEND_CHANGE_EN
  assign bus.change_nickel = chg_r;
`else
  assign bus.change_nickel = 1'b0;
`endif

endmodule
